// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time over valid/ready,
// applies byte-enabled writes to a word array and answers after WAIT_CYCLES wait states.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_we,
    input  logic [3:0]            req_be,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic                    we_r;
    logic [3:0]              be_r;
    logic [3:0]              cnt_r;
    logic                    req_ready_r;
    logic                    busy_r;
    logic                    resp_valid_r;
    logic [DATA_WIDTH-1:0]   resp_rdata_r;
    logic                    resp_err_r;
    logic                    ready_next_s;
    logic                    busy_next_s;

    logic                    accept_s;
    logic                    access_s;
    logic [ADDR_WIDTH-1:0]   op_addr_s;
    logic [DATA_WIDTH-1:0]   op_wdata_s;
    logic                    op_we_s;
    logic [3:0]              op_be_s;
    logic                    op_err_s;
    logic [IDX_W-1:0]        idx_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;

    logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

    // Misaligned or beyond the implemented word range.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != '0);
    endfunction

    assign accept_s = (state_r == ST_IDLE) && req_valid;
    assign access_s = (accept_s && (WAIT_CYCLES == 0)) ||
                      ((state_r == ST_WAIT) && (cnt_r == 4'd0));

    // Zero-wait accesses happen at the accept edge, so they use the live request.
    always_comb begin
        if (state_r == ST_IDLE) begin
            op_addr_s  = req_addr;
            op_wdata_s = req_wdata;
            op_we_s    = req_we;
            op_be_s    = req_be;
        end else begin
            op_addr_s  = addr_r;
            op_wdata_s = wdata_r;
            op_we_s    = we_r;
            op_be_s    = be_r;
        end
    end

    assign op_err_s  = addr_err(op_addr_s);
    assign idx_s     = op_addr_s[IDX_W+1:2];
    assign rd_word_s = mem_r[idx_s];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake outputs for the upcoming state, registered below.
    always_comb begin
        ready_next_s = 1'b0;
        busy_next_s  = 1'b1;
        case (state_next_s)
            ST_IDLE: begin
                ready_next_s = 1'b1;
                busy_next_s  = 1'b0;
            end
            ST_WAIT, ST_RESP: begin
                ready_next_s = 1'b0;
                busy_next_s  = 1'b1;
            end
            default: begin
                ready_next_s = 1'b0;
                busy_next_s  = 1'b1;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            req_ready_r <= ready_next_s;
            busy_r      <= busy_next_s;
        end
    end

    // Request capture at the accept edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_r  <= '0;
            wdata_r <= '0;
            we_r    <= 1'b0;
            be_r    <= 4'b0000;
        end else if (accept_s) begin
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            we_r    <= req_we;
            be_r    <= req_be;
        end
    end

    // Wait-state counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= WAIT_LOAD;
        end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Response registers: one-cycle pulse following the access edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
        end else if (access_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= op_err_s;
            resp_rdata_r <= (op_err_s || op_we_s) ? '0 : rd_word_s;
        end else begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
        end
    end

    // Array write; reset during WAIT drops the pending store.
    always_ff @(posedge clk) begin
        if (reset_n && access_s && op_we_s && !op_err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (op_be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= op_wdata_s[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign busy       = busy_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule
